muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It sits beside the execute path, consuming the two register-file read operands (rs, rt) from the decode stage. It executes MULT, MULTU, DIV and DIVU over 33 cycles, asserting `busy` so the fetch stage holds the PC. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

## Interface
- `DATA_W`, default 32: operand width. The RTL supports only 32.
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-low reset; sampled at the rising edge of `clock`.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  32  multiplicand / dividend.
- `rt_data`  in  32  multiplier / divisor.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight; the fetch stage stalls while it is 1.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result while it is 1.
- `hi`  out  32  HI register, registered output.
- `lo`  out  32  LO register, registered output.

## Operation
- **States:** IDLE, RUN, FIX.
  - IDLE → RUN when `start`=1 at an edge.
  - RUN → FIX after 32 iterations.
  - FIX → IDLE unconditionally.
- **Launch (IDLE edge with `start`=1):**
  - Latch `op`.
  - For signed ops, latch the absolute values of the operands and record the sign flags.
  - Clear the 64-bit accumulator / partial remainder.
  - Set the iteration counter (5-bit) to 0.
- **Multiply:** shift-add, one multiplier bit per RUN cycle, LSB first. The 64-bit product goes to {HI, LO}.
- **Divide:** restoring division, one quotient bit per RUN cycle, MSB first. Quotient goes to LO, remainder to HI. Rounding truncates toward zero.
- **Sign fixup (FIX):**
  - Signed MULT: negate the 64-bit product when the operand signs differ.
  - Signed DIV: negate the quotient when the signs differ; negate the remainder when the dividend is negative.
- **Result write:** HI/LO are written only at the FIX edge.
- **Divide by zero (both DIV and DIVU):** LO=0xFFFFFFFF, HI=rs_data as latched. The unit still takes the full 33 cycles.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO=0x80000000, HI=0 (wraps naturally, no trap).
- **MTHI/MTLO:**
  - In IDLE, `hi_we`/`lo_we` write `wdata` at the edge. Both may be set together.
  - Both are ignored while `busy`=1.
  - If `start` and a write enable are both set at the same IDLE edge, `start` wins and the write is dropped.
- **`start` while busy:** ignored; no queuing.
- **Reset:** `reset`=0 at any edge forces IDLE with `busy`=0, `done`=0, `hi`=0, `lo`=0, and counter 0. An in-flight operation is discarded, with no partial HI/LO update.

## Timing
- Edge E0: `start` accepted.
- `busy`=1 for the 33 cycles following E0:
  - RUN iterations at E1..E32.
  - FIX at E33.
- In the cycle after E33:
  - `busy`=0 and `done`=1 for exactly one cycle.
  - `hi`/`lo` show the new values from that cycle on.
- A new `start` may be accepted at E34, i.e. while `done`=1. That gives back-to-back throughput of one operation per 34 cycles.
- `busy`, `done`, `hi`, `lo` are all registered; no combinational path from the inputs reaches them.
- MFHI/MFLO issued while `busy`=1 stalls in the fetch stage, so reads never see intermediate values.

## Test plan
- **Signed multiply:** MULT rs=7, rt=0xFFFFFFFD (−3) → `busy` high 33 cycles, then `done` pulse; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **Unsigned multiply:** MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Repeat the same operands as MULT → HI=0, LO=1.
- **Signed divide:** DIV rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Unsigned divide:** DIVU rs=100, rt=7 → LO=14, HI=2.
- **Divide by zero:** DIVU rs=0x64, rt=0 → LO=0xFFFFFFFF, HI=0x64, `done` still at cycle 34.
- **Abort and ignored inputs:**
  - `reset`=0 at E10 of a MULT → next cycle `busy`=0, `done`=0, HI=LO=0, and no `done` later.
  - `start` pulsed at E5 of an op → ignored, only one `done`.
  - `hi_we`=1 with `wdata`=0x1234 while busy → HI unchanged.
  - `hi_we`=1 and `start`=1 in the same IDLE cycle → write dropped, operation launches.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 33-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO registers
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [1:0] opr;
  logic sa, sb;
  logic [DATA_W-1:0] a, b, ars, art, dsub, q, r;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0] madd, dsh;
  logic dge;
  assign busy = state != IDLE;
  always_ff @(posedge clock)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (&cnt ? FIX : RUN) : IDLE;
    ars = (~op[0] & rs_data[DATA_W-1]) ? -rs_data : rs_data;
    art = (~op[0] & rt_data[DATA_W-1]) ? -rt_data : rt_data;
    madd = {1'b0, acc[2*DATA_W-1:DATA_W]} + (b[0] ? {1'b0, a} : '0);
    dsh = {acc[2*DATA_W-1:DATA_W], b[DATA_W-1]};
    dge = dsh >= {1'b0, a};
    dsub = dsh[DATA_W-1:0] - a;
    // a zero divisor leaves an all-ones quotient and the dividend as remainder; never negate that quotient
    q = ~|a ? '1 : (sa ^ sb) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    r = sa ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  end
  always_ff @(posedge clock)
    if (!reset) begin
      cnt <= '0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      acc <= '0;
      a <= '0;
      b <= '0;
      opr <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
    end else begin
      done <= state == FIX;
      if (state == IDLE) begin
        if (start) begin
          opr <= op;
          sa <= ~op[0] & rs_data[DATA_W-1];
          sb <= ~op[0] & rt_data[DATA_W-1];
          a <= op[1] ? art : ars;
          b <= op[1] ? ars : art;
          acc <= '0;
          cnt <= '0;
        end else begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
        if (opr[1]) begin
          acc <= {dge ? dsub : dsh[DATA_W-1:0], acc[DATA_W-2:0], dge};
          b <= b << 1;
        end else begin
          acc <= {madd, acc[DATA_W-1:1]};
          b <= b >> 1;
        end
      end else
        {hi, lo} <= opr[1] ? {r, q} : (sa ^ sb) ? -acc : acc;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of multiply, divide, sign fixup, HI/LO writes, abort and throughput
module tb_muldiv_unit;
  logic clock = 0, reset = 0, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [31:0] rs_data = 0, rt_data = 0, wdata = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  int errors = 0, checks = 0;

  muldiv_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .rs_data(rs_data),
    .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int n, output logic d);
    op = o; rs_data = x; rt_data = y; start = 1;
    @(negedge clock);
    start = 0;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clock);
      n++;
    end
    d = done;
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) @(negedge clock);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {busy, done}); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    reset = 1;
    @(negedge clock);
  endtask

  task automatic test_mult;
    int n; logic d;
    run_op(2'b00, 32'd7, 32'hFFFFFFFD, n, d);
    checks++; if (n !== 33) begin errors++; $display("FAIL mult_latency got=%0d exp=33", n); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL mult_done got=%b exp=1", d); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_result got=%h exp=ffffffffffffffeb", {hi, lo}); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_multu;
    int n; logic d;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, n, d);
    checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_result got=%h exp=fffffffe00000001", {hi, lo}); end
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, n, d);
    checks++; if ({hi, lo} !== 64'h00000000_00000001) begin errors++; $display("FAIL mult_neg_result got=%h exp=0000000000000001", {hi, lo}); end
  endtask

  task automatic test_div;
    int n; logic d;
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, n, d);
    checks++; if ({hi, lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow got=%h exp=0000000080000000", {hi, lo}); end
    run_op(2'b10, 32'hFFFFFFFB, 32'd0, n, d);
    checks++; if ({hi, lo} !== 64'hFFFFFFFB_FFFFFFFF) begin errors++; $display("FAIL div_zero_signed got=%h exp=fffffffbffffffff", {hi, lo}); end
  endtask

  task automatic test_divzero;
    int n; logic d;
    run_op(2'b11, 32'h64, 32'd0, n, d);
    checks++; if (n !== 33 || d !== 1'b1) begin errors++; $display("FAIL divzero_timing got=%0d/%b exp=33/1", n, d); end
    checks++; if ({hi, lo} !== 64'h00000064_FFFFFFFF) begin errors++; $display("FAIL divzero_result got=%h exp=00000064ffffffff", {hi, lo}); end
  endtask

  task automatic test_back_to_back;
    int n; logic d;
    run_op(2'b11, 32'd100, 32'd7, n, d);
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_result got=%h exp=000000020000000e", {hi, lo}); end
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, n, d);
    checks++; if (n !== 33 || d !== 1'b1) begin errors++; $display("FAIL b2b_timing got=%0d/%b exp=33/1", n, d); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_result got=%h exp=fffffffffffffffd", {hi, lo}); end
  endtask

  task automatic test_abort;
    int dones = 0;
    op = 2'b01; rs_data = 32'd9; rt_data = 32'd9; start = 1;
    @(negedge clock);
    start = 0;
    repeat (9) @(negedge clock);
    reset = 0;
    @(negedge clock);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_flags got=%b exp=00", {busy, done}); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL abort_hilo got=%h exp=0", {hi, lo}); end
    reset = 1;
    repeat (40) begin
      @(negedge clock);
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_ignored_start;
    int dones = 0;
    op = 2'b01; rs_data = 32'd3; rt_data = 32'd5; start = 1;
    @(negedge clock);
    start = 0;
    repeat (4) @(negedge clock);
    op = 2'b11; rs_data = 32'd100; rt_data = 32'd7; start = 1;
    @(negedge clock);
    start = 0;
    repeat (80) begin
      @(negedge clock);
      if (done) dones++;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
    checks++; if ({hi, lo} !== {32'd0, 32'd15}) begin errors++; $display("FAIL busy_start_result got=%h exp=000000000000000f", {hi, lo}); end
  endtask

  task automatic test_mthi;
    int n; logic d;
    hi_we = 1; lo_we = 1; wdata = 32'hAAAA;
    @(negedge clock);
    hi_we = 0; lo_we = 0;
    checks++; if ({hi, lo} !== {32'hAAAA, 32'hAAAA}) begin errors++; $display("FAIL mthilo got=%h exp=0000aaaa0000aaaa", {hi, lo}); end
    op = 2'b01; rs_data = 32'd2; rt_data = 32'd3; start = 1;
    @(negedge clock);
    start = 0; hi_we = 1; wdata = 32'h1234;
    repeat (5) @(negedge clock);
    hi_we = 0;
    checks++; if (hi !== 32'hAAAA) begin errors++; $display("FAIL mthi_busy got=%h exp=0000aaaa", hi); end
    n = 0;
    while (busy && n < 60) begin
      @(negedge clock);
      n++;
    end
    checks++; if ({hi, lo} !== {32'd0, 32'd6}) begin errors++; $display("FAIL mthi_busy_result got=%h exp=0000000000000006", {hi, lo}); end
    hi_we = 1; wdata = 32'h77;
    @(negedge clock);
    op = 2'b01; rs_data = 32'd4; rt_data = 32'd4; start = 1; wdata = 32'h5555;
    @(negedge clock);
    start = 0; hi_we = 0;
    checks++; if (busy !== 1'b1 || hi !== 32'h77) begin errors++; $display("FAIL start_wins got=%b/%h exp=1/00000077", busy, hi); end
    n = 0;
    while (busy && n < 60) begin
      @(negedge clock);
      n++;
    end
    d = done;
    checks++; if (d !== 1'b1 || {hi, lo} !== {32'd0, 32'd16}) begin errors++; $display("FAIL start_wins_result got=%b/%h exp=1/0000000000000010", d, {hi, lo}); end
  endtask

  initial begin
    @(negedge clock);
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_divzero;
    test_back_to_back;
    test_abort;
    test_ignored_start;
    test_mthi;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
